// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: register word indices,
// the "no interrupt" vector value and the presentation FSM state encoding.
package irq_pkg;

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_ENABLE  = 2'd1;
   localparam logic [1:0] REG_EDGE    = 2'd2;
   localparam logic [1:0] REG_CLAIM   = 2'd3;

   localparam int VEC_NONE = 0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESENT = 2'd1,
      ST_RETIRE  = 2'd2
   } irq_state_t;

endpackage

// File: rtl/irq_arbiter_if.sv
// Register bus between the CPU-side decoder (master) and the interrupt arbiter (slave).
interface irq_arbiter_if;

   logic        reg_sel;
   logic [1:0]  bus_addr;
   logic        bus_write_enable;
   logic [63:0] bus_write_data;
   logic        bus_read_enable;
   logic [63:0] bus_read_data;
   logic        bus_read_done;

   modport master (
      output reg_sel, bus_addr, bus_write_enable, bus_write_data, bus_read_enable,
      input  bus_read_data, bus_read_done
   );

   modport slave (
      input  reg_sel, bus_addr, bus_write_enable, bus_write_data, bus_read_enable,
      output bus_read_data, bus_read_done
   );

endinterface

// File: rtl/irq_arbiter_prio_pick.sv
// Combinational winner select: first set bit of mask, searching upward from start
// and wrapping at N. start must be below N.
module irq_prio_pick #(
   parameter int N     = 8,
   parameter int IDX_W = 4
) (
   input  logic [N-1:0]     mask,
   input  logic [IDX_W-1:0] start,
   output logic             valid,
   output logic [IDX_W-1:0] index
);

   logic [N-1:0] shifted;
   int           pos;

   always_comb begin
      valid   = 1'b0;
      index   = '0;
      shifted = '0;
      pos     = 0;
      for (int k = 0; k < N; k++) begin
         pos = int'(start) + k;
         if (pos >= N) begin
            pos = pos - N;
         end
         shifted = mask >> pos;
         if (!valid && shifted[0]) begin
            valid = 1'b1;
            index = IDX_W'(pos);
         end
      end
   end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: synchronizes sources, keeps PENDING/ENABLE/EDGE/INSERV and presents
// one vector at a time. Define IRQ_ROUND_ROBIN_EN for rotating instead of fixed priority.
module irq_arbiter
   import irq_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int VEC_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   irq_arbiter_if.slave       bus,
   output logic [VEC_W-1:0]   interrupt_vector,
   input  logic               interrupt_ack
);

   if (NUM_SRC < 1 || NUM_SRC > 15 || NUM_SRC + 1 > 2 ** VEC_W) begin : g_param_check
      $error("irq_arbiter: NUM_SRC=%0d invalid or does not fit VEC_W=%0d", NUM_SRC, VEC_W);
   end

   logic [NUM_SRC-1:0] sync1, s, s_prev;
   logic [NUM_SRC-1:0] pending_q, enable_q, edge_q, inserv_q;
   logic [NUM_SRC-1:0] pending, cand, sel_mask, wdata;
   logic [NUM_SRC-1:0] pending_next, inserv_next;
   logic [VEC_W-1:0]   vector_q, cur_idx, pick_idx, start_idx;
   logic               pick_valid, presented_live, ack_take, wr_hit, rd_hit;
   logic [63:0]        read_mux, rdata_q;
   logic               done_q;
   logic               unused_wdata;
   irq_state_t         state;

   assign wdata          = bus.bus_write_data[NUM_SRC-1:0];
   assign unused_wdata   = &{1'b0, bus.bus_write_data[63:NUM_SRC]};
   assign wr_hit         = bus.reg_sel & bus.bus_write_enable;
   assign rd_hit         = bus.reg_sel & bus.bus_read_enable;
   // Level sources mirror the synchronized line directly; only edge sources are latched.
   assign pending        = (pending_q & edge_q) | (s & ~edge_q);
   assign cand           = pending & enable_q & ~inserv_q;
   assign sel_mask       = NUM_SRC'(1) << cur_idx;
   assign presented_live = |(sel_mask & pending & enable_q);
   assign ack_take       = (state == ST_PRESENT) && interrupt_ack;

`ifdef IRQ_ROUND_ROBIN_EN
   logic [VEC_W-1:0] rr_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (ack_take) begin
         rr_ptr <= (cur_idx == VEC_W'(NUM_SRC - 1)) ? '0 : cur_idx + VEC_W'(1);
      end
   end

   assign start_idx = rr_ptr;
`else
   assign start_idx = '0;
`endif

   irq_prio_pick #(.N(NUM_SRC), .IDX_W(VEC_W)) u_pick (
      .mask  (cand),
      .start (start_idx),
      .valid (pick_valid),
      .index (pick_idx)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1  <= '0;
         s      <= '0;
         s_prev <= '0;
      end else begin
         sync1  <= irq_src;
         s      <= sync1;
         s_prev <= s;
      end
   end

   // A new rising edge is ORed in last so it survives a same-cycle W1C or ack clear.
   always_comb begin
      pending_next = pending_q;
      if (wr_hit && bus.bus_addr == REG_PENDING) begin
         pending_next = pending_next & ~wdata;
      end
      if (ack_take) begin
         pending_next = pending_next & ~sel_mask;
      end
      pending_next = (pending_next | (s & ~s_prev)) & edge_q;

      inserv_next = inserv_q & ~(~edge_q & ~s);
      if (state == ST_RETIRE) begin
         inserv_next = inserv_next & ~edge_q;
      end
      if (ack_take) begin
         inserv_next = inserv_next | sel_mask;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
         enable_q  <= '0;
         edge_q    <= '0;
         inserv_q  <= '0;
      end else begin
         if (wr_hit && bus.bus_addr == REG_ENABLE) begin
            enable_q <= wdata;
         end
         if (wr_hit && bus.bus_addr == REG_EDGE) begin
            edge_q <= wdata;
         end
         pending_q <= pending_next;
         inserv_q  <= inserv_next;
      end
   end

   // Once presented, a vector is only withdrawn by ack or by its own source going away.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         vector_q <= VEC_W'(VEC_NONE);
         cur_idx  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  vector_q <= pick_idx + VEC_W'(1);
                  cur_idx  <= pick_idx;
                  state    <= ST_PRESENT;
               end else begin
                  vector_q <= VEC_W'(VEC_NONE);
               end
            end
            ST_PRESENT: begin
               if (interrupt_ack) begin
                  vector_q <= VEC_W'(VEC_NONE);
                  state    <= ST_RETIRE;
               end else if (!presented_live) begin
                  vector_q <= VEC_W'(VEC_NONE);
                  state    <= ST_IDLE;
               end
            end
            ST_RETIRE: begin
               vector_q <= VEC_W'(VEC_NONE);
               state    <= ST_IDLE;
            end
            default: begin
               vector_q <= VEC_W'(VEC_NONE);
               state    <= ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      read_mux = '0;
      case (bus.bus_addr)
         REG_PENDING: read_mux = 64'(pending);
         REG_ENABLE:  read_mux = 64'(enable_q);
         REG_EDGE:    read_mux = 64'(edge_q);
         REG_CLAIM:   read_mux = 64'(vector_q);
         default:     read_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= rd_hit;
         if (rd_hit) begin
            rdata_q <= read_mux;
         end
      end
   end

   assign bus.bus_read_data = rdata_q;
   assign bus.bus_read_done = done_q;
   assign interrupt_vector  = vector_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter; expected values are hand-derived per scenario.
module tb_irq_arbiter;
   import irq_pkg::*;

   localparam int NUM_SRC = 8;
   localparam int VEC_W   = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic [NUM_SRC-1:0] irq_src;
   logic [VEC_W-1:0]   interrupt_vector;
   logic               interrupt_ack;
   logic [63:0]        rd_val;
   int                 compared   = 0;
   int                 mismatched = 0;

   irq_arbiter_if bus ();

   irq_arbiter #(.NUM_SRC(NUM_SRC), .VEC_W(VEC_W)) dut (
      .clk              (clk),
      .reset            (reset),
      .irq_src          (irq_src),
      .bus              (bus.slave),
      .interrupt_vector (interrupt_vector),
      .interrupt_ack    (interrupt_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle pulse on the selected interrupt lines.
   task automatic applyStimulus(input logic [NUM_SRC-1:0] pattern);
      irq_src = pattern;
      tick(1);
      irq_src = '0;
   endtask

   task automatic bus_write(input logic [1:0] addr, input logic [63:0] data);
      bus.reg_sel          = 1'b1;
      bus.bus_write_enable = 1'b1;
      bus.bus_addr         = addr;
      bus.bus_write_data   = data;
      tick(1);
      bus.reg_sel          = 1'b0;
      bus.bus_write_enable = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] addr, output logic [63:0] data);
      bus.reg_sel         = 1'b1;
      bus.bus_read_enable = 1'b1;
      bus.bus_addr        = addr;
      tick(1);
      bus.reg_sel         = 1'b0;
      bus.bus_read_enable = 1'b0;
      data = bus.bus_read_data;
   endtask

   task automatic wait_vector(input string tag, input logic [VEC_W-1:0] expected);
      int n = 0;
      while (interrupt_vector == '0 && n < 20) begin
         tick(1);
         n++;
      end
      checkOutput(tag, 64'(interrupt_vector), 64'(expected));
   endtask

   task automatic do_ack();
      interrupt_ack = 1'b1;
      tick(1);
      interrupt_ack = 1'b0;
   endtask

   initial begin
      reset                = 1'b1;
      irq_src              = '0;
      interrupt_ack        = 1'b0;
      bus.reg_sel          = 1'b0;
      bus.bus_addr         = 2'd0;
      bus.bus_write_enable = 1'b0;
      bus.bus_write_data   = '0;
      bus.bus_read_enable  = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(1);

      // Reset state and read handshake
      checkOutput("rst_vector", 64'(interrupt_vector), 64'h0);
      bus_read(REG_PENDING, rd_val);
      checkOutput("rst_pending", rd_val, 64'h0);
      checkOutput("rd_done_pulse", 64'(bus.bus_read_done), 64'h1);
      tick(1);
      checkOutput("rd_done_low", 64'(bus.bus_read_done), 64'h0);
      bus_read(REG_ENABLE, rd_val);
      checkOutput("rst_enable", rd_val, 64'h0);
      bus_read(REG_EDGE, rd_val);
      checkOutput("rst_edge", rd_val, 64'h0);
      bus_read(REG_CLAIM, rd_val);
      checkOutput("rst_claim", rd_val, 64'h0);

      // Two edge sources pulsed together: lowest first, gap, then the other
      bus_write(REG_ENABLE, 64'h05);
      bus_write(REG_EDGE, 64'h05);
      applyStimulus(8'h05);
      wait_vector("t1_first", 4'd1);
      bus_read(REG_CLAIM, rd_val);
      checkOutput("t1_claim", rd_val, 64'h1);
      bus_read(REG_PENDING, rd_val);
      checkOutput("t1_pending", rd_val, 64'h05);
      do_ack();
      checkOutput("t1_ack_zero", 64'(interrupt_vector), 64'h0);
      tick(1);
      checkOutput("t1_gap", 64'(interrupt_vector), 64'h0);
      wait_vector("t1_second", 4'd3);
      do_ack();
      tick(4);
      checkOutput("t1_done_idle", 64'(interrupt_vector), 64'h0);
      bus_read(REG_PENDING, rd_val);
      checkOutput("t1_pending_clr", rd_val, 64'h0);

      // Level source stays in service until the line drops and re-rises
      bus_write(REG_ENABLE, 64'h02);
      bus_write(REG_EDGE, 64'h00);
      irq_src = 8'h02;
      wait_vector("t2_level", 4'd2);
      do_ack();
      checkOutput("t2_ack_zero", 64'(interrupt_vector), 64'h0);
      tick(6);
      checkOutput("t2_held_off", 64'(interrupt_vector), 64'h0);
      bus_read(REG_PENDING, rd_val);
      checkOutput("t2_pending_lvl", rd_val, 64'h02);
      irq_src = 8'h00;
      tick(4);
      irq_src = 8'h02;
      wait_vector("t2_rerise", 4'd2);
      do_ack();
      irq_src = 8'h00;
      tick(6);

      // No preemption of a presented vector by a higher priority source
      bus_write(REG_ENABLE, 64'h09);
      bus_write(REG_EDGE, 64'h09);
      applyStimulus(8'h08);
      wait_vector("t3_src3", 4'd4);
      applyStimulus(8'h01);
      tick(6);
      checkOutput("t3_no_preempt", 64'(interrupt_vector), 64'h4);
      do_ack();
      wait_vector("t3_src0", 4'd1);
      do_ack();
      tick(4);

      // Clearing ENABLE or PENDING of the presented source withdraws the vector
      bus_write(REG_ENABLE, 64'h04);
      bus_write(REG_EDGE, 64'h04);
      applyStimulus(8'h04);
      wait_vector("t4_present", 4'd3);
      bus_write(REG_ENABLE, 64'h00);
      tick(1);
      checkOutput("t4_disable_drop", 64'(interrupt_vector), 64'h0);
      bus_write(REG_ENABLE, 64'h04);
      wait_vector("t4_reenable", 4'd3);
      bus_write(REG_PENDING, 64'h04);
      tick(1);
      checkOutput("t4_w1c_drop", 64'(interrupt_vector), 64'h0);
      tick(2);
      checkOutput("t4_stays_idle", 64'(interrupt_vector), 64'h0);

      // W1C alone clears; W1C colliding with a new rising edge loses
      bus_write(REG_ENABLE, 64'h00);
      bus_write(REG_EDGE, 64'h10);
      applyStimulus(8'h10);
      tick(4);
      bus_read(REG_PENDING, rd_val);
      checkOutput("t5_set", rd_val, 64'h10);
      bus_write(REG_PENDING, 64'h10);
      bus_read(REG_PENDING, rd_val);
      checkOutput("t5_w1c", rd_val, 64'h0);
      irq_src = 8'h10;
      tick(2);
      bus_write(REG_PENDING, 64'h10);
      irq_src = 8'h00;
      bus_read(REG_PENDING, rd_val);
      checkOutput("t5_set_wins", rd_val, 64'h10);

      // Read during write returns the old value; CLAIM and upper data bits ignore writes
      bus_write(REG_EDGE, 64'h33);
      bus.reg_sel          = 1'b1;
      bus.bus_write_enable = 1'b1;
      bus.bus_read_enable  = 1'b1;
      bus.bus_addr         = REG_EDGE;
      bus.bus_write_data   = 64'h44;
      tick(1);
      bus.reg_sel          = 1'b0;
      bus.bus_write_enable = 1'b0;
      bus.bus_read_enable  = 1'b0;
      checkOutput("t6_pre_write", bus.bus_read_data, 64'h33);
      bus_read(REG_EDGE, rd_val);
      checkOutput("t6_post_write", rd_val, 64'h44);
      bus_write(REG_CLAIM, 64'h0F);
      bus_read(REG_CLAIM, rd_val);
      checkOutput("t6_claim_ro", rd_val, 64'h0);
      bus_write(REG_ENABLE, 64'hFFFF_FFFF_FFFF_FF00);
      bus_read(REG_ENABLE, rd_val);
      checkOutput("t6_upper_ignored", rd_val, 64'h0);

      // Asynchronous reset while presenting
      bus_write(REG_ENABLE, 64'h02);
      bus_write(REG_EDGE, 64'h02);
      applyStimulus(8'h02);
      wait_vector("t7_present", 4'd2);
      reset = 1'b1;
      #1;
      checkOutput("t7_async_reset", 64'(interrupt_vector), 64'h0);
      tick(1);
      reset = 1'b0;
      tick(1);
      bus_read(REG_ENABLE, rd_val);
      checkOutput("t7_enable", rd_val, 64'h0);
      bus_read(REG_EDGE, rd_val);
      checkOutput("t7_edge", rd_val, 64'h0);
      bus_read(REG_PENDING, rd_val);
      checkOutput("t7_pending", rd_val, 64'h0);

      // Sources 0 and 1 both pending each round
      bus_write(REG_EDGE, 64'h03);
      for (int i = 0; i < 4; i++) begin
         logic [VEC_W-1:0] exp_vec;
`ifdef IRQ_ROUND_ROBIN_EN
         exp_vec = (i % 2 == 0) ? 4'd1 : 4'd2;
`else
         exp_vec = 4'd1;
`endif
         bus_write(REG_ENABLE, 64'h00);
         applyStimulus(8'h03);
         tick(4);
         bus_write(REG_ENABLE, 64'h03);
         wait_vector($sformatf("t8_round_%0d", i), exp_vec);
         do_ack();
         tick(2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
